key_press_controller: RTL and testbench
=======================================

// Module: key_press_controller
// PURPOSE
//   Front-end sequencer for the switch-register / hex-counter datapath.
//   Synchronises and debounces the active-low LOAD and CLEAR pushbuttons.
//   Emits single-cycle load/increment/clear strobes, with auto-repeat increment on long hold.
//   Captures sw_i at each press.
//   Sits between board keys and the ledr/hex counter registers, replacing raw edge detection.
// PARAMETERS
//   DEBOUNCE_CYC  1_000_000   cycles of stable synced input before debounced level changes (10 ms @100 MHz)
//   HOLD_CYC      50_000_000  cycles LOAD held (after press strobe) before auto-repeat starts
//   REPEAT_CYC    10_000_000  cycles between auto-repeat increments
//   DATA_W        10          switch/data width
// PORTS
//   clk100_i    in   1       system clock, 100 MHz
//   rstn_i      in   1       asynchronous active-low reset
//   key_i       in   1       raw LOAD pushbutton, active-low (0 = pressed), asynchronous
//   clr_key_i   in   1       raw CLEAR pushbutton, active-low, asynchronous
//   sw_i        in   DATA_W  switch value, sampled at LOAD press
//   data_o      out  DATA_W  switch value captured at last LOAD press
//   load_stb_o  out  1       1-cycle strobe: datapath loads data_o
//   inc_stb_o   out  1       1-cycle strobe: datapath counter +1
//   clr_stb_o   out  1       1-cycle strobe: datapath clears register and counter
//   repeat_o    out  1       high while FSM in REPEAT
// BEHAVIOUR
//   Reset (rstn_i=0, async): sync flops and debounced levels = 1 (released); debounce/hold timers = 0.
//     FSM = IDLE; data_o = 0; all strobes = 0; repeat_o = 0. Applies mid-operation immediately.
//   Sync: 2-flop synchroniser per key.
//   Debounce, per key: counter increments while synced level != debounced level, else clears to 0.
//     When counter reaches DEBOUNCE_CYC-1 with mismatch: debounced level <= synced level, counter <= 0.
//     Any reversion before that clears the counter: glitches shorter than DEBOUNCE_CYC are ignored.
//   Press event = debounced level 1->0. Release = 0->1. All outputs are registered.
//   Latency: raw key held from cycle 0 -> synced at cycle 2 -> debounced at 2+DEBOUNCE_CYC.
//     Strobe high on cycle 3+DEBOUNCE_CYC only.
//   FSM states (LOAD key):
//     IDLE:     LOAD press -> PRESSED. Assert load_stb_o and inc_stb_o; data_o <= sw_i of that cycle.
//               Hold timer <= 0.
//     PRESSED:  hold timer +1 per cycle. Release -> IDLE, no strobe.
//               Timer == HOLD_CYC-1 -> REPEAT, inc_stb_o pulse, timer <= 0.
//     REPEAT:   repeat_o=1; timer +1. Timer == REPEAT_CYC-1 -> inc_stb_o pulse, timer <= 0.
//               Release -> IDLE, no strobe.
//     WAIT_REL: no strobes; release -> IDLE.
//   CLEAR press: clr_stb_o 1 cycle. Priority over LOAD strobes in the same cycle; load/inc suppressed.
//     If LOAD debounced level is pressed, FSM -> WAIT_REL; else FSM -> IDLE. data_o unchanged.
//   CLEAR held is not auto-repeated; one clr_stb_o per press.
//   At most one inc_stb_o per cycle; strobes never stretch past 1 cycle.
//   Timers are width clog2(max(HOLD_CYC,REPEAT_CYC)) and never wrap: reset on each state change.
//   Counter wrap (8-bit) is a datapath concern; the controller only issues strobes.
// TESTING  (DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8, DATA_W=10)
//   1 Reset: rstn_i=0 mid-REPEAT -> all strobes/repeat_o 0, data_o=0 same cycle; FSM IDLE after release.
//   2 Clean press: sw_i=10'h2A5, key_i 1->0 at cyc 0 -> load_stb_o=inc_stb_o=1 only at cyc 7.
//     data_o=10'h2A5; release -> no strobe.
//   3 Bounce: key_i low 3 cycles, high 1, low 3, high -> zero strobes.
//     Same glitch pattern then held low -> exactly one press.
//   4 Auto-repeat: hold key 60 cycles after press strobe -> inc_stb_o at +20, +28, +36, +44, +52.
//     repeat_o=1 from +20 to release.
//   5 Clear during hold: in REPEAT press clr_key_i -> one clr_stb_o, no further inc_stb_o.
//     FSM stays in WAIT_REL until key_i released; re-press gives new load strobe.
//   6 Simultaneous: key_i and clr_key_i fall same cycle -> only clr_stb_o; FSM WAIT_REL.
//     data_o unchanged.

Source files
------------

// File: rtl/key_press_controller_if.sv
// Board-key side bundle of the key press controller: raw keys and switches in,
// captured data and single-cycle datapath strobes out.
interface key_press_controller_if #(
    parameter int DATA_W = 10
);
    logic              key_i;
    logic              clr_key_i;
    logic [DATA_W-1:0] sw_i;
    logic [DATA_W-1:0] data_o;
    logic              load_stb_o;
    logic              inc_stb_o;
    logic              clr_stb_o;
    logic              repeat_o;

    modport master (
        output key_i, clr_key_i, sw_i,
        input  data_o, load_stb_o, inc_stb_o, clr_stb_o, repeat_o
    );

    modport slave (
        input  key_i, clr_key_i, sw_i,
        output data_o, load_stb_o, inc_stb_o, clr_stb_o, repeat_o
    );
endinterface

// File: rtl/key_press_controller.sv
// Debounced LOAD/CLEAR key sequencer: turns noisy active-low pushbuttons into
// single-cycle load/increment/clear strobes, with auto-repeat on a long LOAD hold.
module key_press_controller #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int DATA_W       = 10
) (
    input  logic                  clk100_i,
    input  logic                  rstn_i,
    key_press_controller_if.slave bus
);

    localparam int DCW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]  REP_LAST  = TW'(REPEAT_CYC - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESSED  = 2'd1;
    localparam logic [1:0] S_REPEAT   = 2'd2;
    localparam logic [1:0] S_WAIT_REL = 2'd3;

    // Bit 0 is the LOAD key, bit 1 the CLEAR key; 1 means released.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          debLevel_q, debPrev_q;
    logic [1:0][DCW-1:0] debCnt_q;

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              loadStb_q, loadStb_d;
    logic              incStb_q, incStb_d;
    logic              clrStb_q, clrStb_d;
    logic              repeat_q;

    logic loadPress, loadRelease, clrPress, loadHeld;

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            debLevel_q <= 2'b11;
            debPrev_q  <= 2'b11;
            debCnt_q   <= '0;
        end else begin
            sync1_q   <= {bus.clr_key_i, bus.key_i};
            sync2_q   <= sync1_q;
            debPrev_q <= debLevel_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == debLevel_q[i]) begin
                    debCnt_q[i] <= '0;
                end else if (debCnt_q[i] == DB_LAST) begin
                    debLevel_q[i] <= sync2_q[i];
                    debCnt_q[i]   <= '0;
                end else begin
                    debCnt_q[i] <= debCnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Events are taken one cycle after the debounced level moves, so every strobe is registered.
    assign loadPress   =  debPrev_q[0] & ~debLevel_q[0];
    assign loadRelease = ~debPrev_q[0] &  debLevel_q[0];
    assign clrPress    =  debPrev_q[1] & ~debLevel_q[1];
    assign loadHeld    = ~debLevel_q[0];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        data_d    = data_q;
        loadStb_d = 1'b0;
        incStb_d  = 1'b0;
        clrStb_d  = 1'b0;
        if (clrPress) begin
            clrStb_d = 1'b1;
            state_d  = loadHeld ? S_WAIT_REL : S_IDLE;
            timer_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (loadPress) begin
                        state_d   = S_PRESSED;
                        loadStb_d = 1'b1;
                        incStb_d  = 1'b1;
                        data_d    = bus.sw_i;
                        timer_d   = '0;
                    end
                end
                S_PRESSED: begin
                    if (loadRelease) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end else if (timer_q == HOLD_LAST) begin
                        state_d  = S_REPEAT;
                        incStb_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (loadRelease) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end else if (timer_q == REP_LAST) begin
                        incStb_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (loadRelease) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            data_q    <= '0;
            loadStb_q <= 1'b0;
            incStb_q  <= 1'b0;
            clrStb_q  <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            loadStb_q <= loadStb_d;
            incStb_q  <= incStb_d;
            clrStb_q  <= clrStb_d;
            repeat_q  <= (state_d == S_REPEAT);
        end
    end

    assign bus.data_o     = data_q;
    assign bus.load_stb_o = loadStb_q;
    assign bus.inc_stb_o  = incStb_q;
    assign bus.clr_stb_o  = clrStb_q;
    assign bus.repeat_o   = repeat_q;

endmodule

// File: tb/tb_key_press_controller.sv
// Bench for key_press_controller: directed scenarios plus a random key run, all
// compared cycle by cycle against a window-based behavioural model.
module tb_key_press_controller;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;
    localparam int W = 10;

    localparam int M_IDLE = 0;
    localparam int M_HELD = 1;
    localparam int M_WAIT = 2;

    logic clk = 1'b0;
    logic rstn;
    int   nChecks = 0;
    int   nFail   = 0;

    always #5 clk = ~clk;

    key_press_controller_if #(.DATA_W(W)) bus ();

    key_press_controller #(
        .DEBOUNCE_CYC(D),
        .HOLD_CYC    (H),
        .REPEAT_CYC  (R),
        .DATA_W      (W)
    ) dut (
        .clk100_i(clk),
        .rstn_i  (rstn),
        .bus     (bus)
    );

    // Model state: raw key history (bit j = value j+1 edges ago) and debounced level history.
    logic [15:0]  rawHist, clrHist;
    logic [1:0]   ldDebH, clDebH;
    int           mode, age;
    logic [W-1:0] mData;
    logic         mLoad, mInc, mClr, mRep;

    task automatic modelReset();
        rawHist = '1;
        clrHist = '1;
        ldDebH  = 2'b11;
        clDebH  = 2'b11;
        mode    = M_IDLE;
        age     = 0;
        mData   = '0;
        mLoad   = 1'b0;
        mInc    = 1'b0;
        mClr    = 1'b0;
        mRep    = 1'b0;
    endtask

    // A debounced level follows its key once the key has sat at one value for D synced samples.
    function automatic logic nextDeb(input logic [15:0] hist, input logic cur);
        logic [D-1:0] win;
        win = hist[D+1:2];
        if (win == '0) return 1'b0;
        if (win == '1) return 1'b1;
        return cur;
    endfunction

    task automatic modelEdge();
        logic lPress, lRel, cPress, lHeld;
        rawHist = {rawHist[14:0], bus.key_i};
        clrHist = {clrHist[14:0], bus.clr_key_i};
        lPress  =  ldDebH[1] && !ldDebH[0];
        lRel    = !ldDebH[1] &&  ldDebH[0];
        cPress  =  clDebH[1] && !clDebH[0];
        lHeld   = !ldDebH[0];
        ldDebH  = {ldDebH[0], nextDeb(rawHist, ldDebH[0])};
        clDebH  = {clDebH[0], nextDeb(clrHist, clDebH[0])};
        mLoad = 1'b0;
        mInc  = 1'b0;
        mClr  = 1'b0;
        if (cPress) begin
            mClr = 1'b1;
            mode = lHeld ? M_WAIT : M_IDLE;
        end else if (mode == M_IDLE) begin
            if (lPress) begin
                mLoad = 1'b1;
                mInc  = 1'b1;
                mData = bus.sw_i;
                mode  = M_HELD;
                age   = 0;
            end
        end else if (lRel) begin
            mode = M_IDLE;
        end else if (mode == M_HELD) begin
            age++;
            if (age == H || (age > H && (age - H) % R == 0)) mInc = 1'b1;
        end
        mRep = (mode == M_HELD) && (age >= H);
    endtask

    function automatic logic [W+3:0] dutOuts();
        return {bus.data_o, bus.load_stb_o, bus.inc_stb_o, bus.clr_stb_o, bus.repeat_o};
    endfunction

    function automatic logic [W+3:0] modelOuts();
        return {mData, mLoad, mInc, mClr, mRep};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rstn) modelEdge();
        else modelReset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn          = 1'b1;
        bus.key_i     = 1'b1;
        bus.clr_key_i = 1'b1;
        bus.sw_i      = '0;
        #2 rstn = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (dutOuts() !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_state got %h expected %h", dutOuts(), {(W+4){1'b0}});
        end
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL reset_idle[%0d] got %h expected %h", k, dutOuts(), modelOuts());
            end
        end
    endtask

    task automatic test_clean_press();
        int loads = 0;
        bus.sw_i  = 10'h2A5;
        bus.key_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            loads += int'(bus.load_stb_o);
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL press_model[%0d] got %h expected %h", k, dutOuts(), modelOuts());
            end
            nChecks++;
            if ({bus.load_stb_o, bus.inc_stb_o} !== ((k == 7) ? 2'b11 : 2'b00)) begin
                nFail++;
                $display("[TB] FAIL press_latency[%0d] got %b expected %b", k,
                         {bus.load_stb_o, bus.inc_stb_o}, (k == 7) ? 2'b11 : 2'b00);
            end
        end
        nChecks++;
        if (bus.data_o !== 10'h2A5) begin
            nFail++;
            $display("[TB] FAIL press_data got %h expected %h", bus.data_o, 10'h2A5);
        end
        bus.sw_i  = 10'h0AA;
        bus.key_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            loads += int'(bus.load_stb_o | bus.inc_stb_o);
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL release_model[%0d] got %h expected %h", k, dutOuts(), modelOuts());
            end
        end
        nChecks++;
        if (loads != 1) begin
            nFail++;
            $display("[TB] FAIL press_strobe_count got %0d expected 1", loads);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] glitch = 8'b1000_1000;
        int         strobes = 0;
        for (int rep = 0; rep < 2; rep++) begin
            strobes = 0;
            for (int k = 0; k < 8 + 18; k++) begin
                if (k < 8) bus.key_i = glitch[7-k];
                else bus.key_i = (rep == 0) ? 1'b1 : 1'b0;
                tick();
                strobes += int'(bus.load_stb_o);
                nChecks++;
                if (dutOuts() !== modelOuts()) begin
                    nFail++;
                    $display("[TB] FAIL bounce%0d_model[%0d] got %h expected %h", rep, k, dutOuts(), modelOuts());
                end
            end
            nChecks++;
            if (strobes != rep) begin
                nFail++;
                $display("[TB] FAIL bounce%0d_presses got %0d expected %0d", rep, strobes, rep);
            end
        end
        bus.key_i = 1'b1;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_auto_repeat();
        bit found = 0;
        bus.sw_i  = 10'h11C;
        bus.key_i = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            tick();
            found = bus.load_stb_o;
        end
        nChecks++;
        if (!found) begin
            nFail++;
            $display("[TB] FAIL repeat_press_timeout got 0 expected 1");
        end
        for (int t = 1; t <= 60; t++) begin
            logic expInc;
            tick();
            expInc = (t == 20) || (t == 28) || (t == 36) || (t == 44) || (t == 52);
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL repeat_model[+%0d] got %h expected %h", t, dutOuts(), modelOuts());
            end
            if (t <= 56) begin
                nChecks++;
                if ({bus.inc_stb_o, bus.repeat_o} !== {expInc, (t >= 20) ? 1'b1 : 1'b0}) begin
                    nFail++;
                    $display("[TB] FAIL repeat_timing[+%0d] got %b expected %b", t,
                             {bus.inc_stb_o, bus.repeat_o}, {expInc, (t >= 20) ? 1'b1 : 1'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        int strobes = 0;
        #2 rstn = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (dutOuts() !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_mid_repeat got %h expected %h", dutOuts(), {(W+4){1'b0}});
        end
        bus.key_i = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            strobes += int'(bus.load_stb_o | bus.inc_stb_o | bus.clr_stb_o | bus.repeat_o);
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL post_reset_model[%0d] got %h expected %h", k, dutOuts(), modelOuts());
            end
        end
        nChecks++;
        if (strobes != 0) begin
            nFail++;
            $display("[TB] FAIL post_reset_quiet got %0d expected 0", strobes);
        end
    endtask

    task automatic test_clear_during_hold();
        bit found = 0;
        bit seenClr = 0;
        int clrs = 0;
        int incAfter = 0;
        bus.sw_i  = 10'h0F3;
        bus.key_i = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            tick();
            found = bus.load_stb_o;
        end
        nChecks++;
        if (!found) begin
            nFail++;
            $display("[TB] FAIL clear_press_timeout got 0 expected 1");
        end
        for (int t = 0; t < 24 + 12 + 40; t++) begin
            bus.clr_key_i = (t >= 24 && t < 36) ? 1'b0 : 1'b1;
            tick();
            if (seenClr) incAfter += int'(bus.inc_stb_o);
            if (bus.clr_stb_o) seenClr = 1;
            clrs += int'(bus.clr_stb_o);
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL clear_model[%0d] got %h expected %h", t, dutOuts(), modelOuts());
            end
        end
        nChecks++;
        if (clrs != 1 || incAfter != 0 || bus.repeat_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL clear_once got clr=%0d inc=%0d rep=%b expected clr=1 inc=0 rep=0",
                     clrs, incAfter, bus.repeat_o);
        end
        bus.key_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL wait_rel_model[%0d] got %h expected %h", k, dutOuts(), modelOuts());
            end
        end
        found     = 0;
        bus.sw_i  = 10'h31C;
        bus.key_i = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            tick();
            found = bus.load_stb_o;
        end
        nChecks++;
        if (!found || bus.data_o !== 10'h31C) begin
            nFail++;
            $display("[TB] FAIL repress_load got stb=%b data=%h expected stb=1 data=%h", found, bus.data_o, 10'h31C);
        end
        bus.key_i = 1'b1;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_simultaneous();
        int clrs = 0;
        int others = 0;
        bus.sw_i      = 10'h155;
        bus.key_i     = 1'b0;
        bus.clr_key_i = 1'b0;
        for (int k = 0; k < 44; k++) begin
            if (k == 14) bus.clr_key_i = 1'b1;
            tick();
            clrs   += int'(bus.clr_stb_o);
            others += int'(bus.load_stb_o | bus.inc_stb_o | bus.repeat_o);
            nChecks++;
            if (dutOuts() !== modelOuts()) begin
                nFail++;
                $display("[TB] FAIL simul_model[%0d] got %h expected %h", k, dutOuts(), modelOuts());
            end
        end
        nChecks++;
        if (clrs != 1 || others != 0 || bus.data_o !== 10'h31C) begin
            nFail++;
            $display("[TB] FAIL simul_clear_only got clr=%0d other=%0d data=%h expected clr=1 other=0 data=%h",
                     clrs, others, bus.data_o, 10'h31C);
        end
        bus.key_i = 1'b1;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 40; seg++) begin
            int len = $urandom_range(1, 40);
            bus.key_i     = 1'($urandom_range(0, 1));
            bus.clr_key_i = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < len; k++) begin
                bus.sw_i = W'($urandom);
                tick();
                nChecks++;
                if (dutOuts() !== modelOuts()) begin
                    nFail++;
                    $display("[TB] FAIL random_model[%0d.%0d] got %h expected %h", seg, k, dutOuts(), modelOuts());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_reset_mid_repeat();
        test_clear_during_hold();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
